// File: rtl/sram_loader_pkg.sv
// Shared loader definitions: word width, frame sync marker and FSM state encodings.
package sram_loader_pkg;

  localparam int unsigned WORD_SIZE_DEF = 8;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    CHECK = 3'd4,
    RUN   = 3'd5,
    ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/sram_loader_checksum.sv
// Running modulo-2^W sum of frame data bytes and compare against the trailing checksum byte.
// Only present when SRAM_LOADER_CHECKSUM_EN is defined.
`ifdef SRAM_LOADER_CHECKSUM_EN
module load_checksum #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         add_i,
  input  logic [W-1:0] data_i,
  output logic         match_c
);

  logic [W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match_c = (data_i == sum_q);

endmodule
`endif

// File: rtl/sram_loader.sv
// Byte-stream SRAM loader: SYNC, ADDR, COUNT, DATA... frames written to SRAM, then CPU released.
// Optional trailing checksum byte enabled by SRAM_LOADER_CHECKSUM_EN.
module sram_loader
  import sram_loader_pkg::*;
#(
  parameter int unsigned          word_size = WORD_SIZE_DEF,
  parameter logic [word_size-1:0] SYNC_BYTE = word_size'(SYNC_BYTE_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 load_req,
  output logic                 mem_we,
  output logic [word_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_data,
  output logic                 cpu_rst_n,
  output logic                 done,
  output logic                 error
);

  // One extra bit so a count byte of 0 can stand for a full 2^word_size bytes.
  localparam int unsigned CNT_W = word_size + 1;

  state_e               state_q, state_d;
  logic [word_size-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mem_we_q, mem_we_d;
  logic [word_size-1:0] mem_addr_q, mem_addr_d;
  logic [word_size-1:0] mem_data_q, mem_data_d;
  logic                 in_ready_q, in_ready_d;
  logic                 cpu_rst_n_q, cpu_rst_n_d;
  logic                 done_q, done_d;
  logic                 accept_c;

  assign accept_c = in_valid & in_ready_q;

`ifdef SRAM_LOADER_CHECKSUM_EN
  logic error_q, error_d;
  logic sum_match_c;

  load_checksum #(.W(word_size)) u_checksum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == IDLE),
    .add_i   ((state_q == DATA) && accept_c),
    .data_i  (in_data),
    .match_c (sum_match_c)
  );
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c && (in_data == SYNC_BYTE)) state_d = ADDR;
      end
      ADDR: begin
        if (accept_c) begin
          ptr_d   = in_data;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (accept_c) begin
          cnt_d   = (in_data == '0) ? {1'b1, {word_size{1'b0}}} : CNT_W'(in_data);
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept_c) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q;
          mem_data_d = in_data;
          ptr_d      = ptr_q + word_size'(1);
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
`ifdef SRAM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = RUN;
`endif
          end
        end
      end
      CHECK: begin
`ifdef SRAM_LOADER_CHECKSUM_EN
        if (accept_c) state_d = sum_match_c ? RUN : ERR;
`else
        state_d = IDLE;
`endif
      end
      RUN, ERR: begin
        if (load_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // in_ready tracks the state being entered; status flags lag the state by one cycle.
    in_ready_d  = !((state_d == RUN) || (state_d == ERR));
    cpu_rst_n_d = (state_q == RUN);
    done_d      = (state_q == RUN);
`ifdef SRAM_LOADER_CHECKSUM_EN
    error_d     = (state_q == ERR);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      in_ready_q  <= 1'b1;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SRAM_LOADER_CHECKSUM_EN
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      in_ready_q  <= in_ready_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
`ifdef SRAM_LOADER_CHECKSUM_EN
      error_q     <= error_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign done      = done_q;
`ifdef SRAM_LOADER_CHECKSUM_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule
